// File: rtl/cu_pkg.sv
`default_nettype none
// cu_pkg: state encoding, opcode and ALU-operation constants for param_control_unit.
// Revision 1.0
package cu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MV    = 3'd2,
    MVI   = 3'd3,
    OP1   = 3'd4,
    OP2   = 3'd5,
    WB    = 3'd6,
    ILL   = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MV   = 3'd0;
  localparam logic [2:0] OPC_MVI  = 3'd1;
  localparam logic [2:0] OPC_ADD  = 3'd2;
  localparam logic [2:0] OPC_SUB  = 3'd3;
  localparam logic [2:0] OPC_MVNZ = 3'd4;
  localparam logic [2:0] OPC_AND  = 3'd5;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

endpackage
`default_nettype wire

// File: rtl/param_control_unit_onehot_dec.sv
`default_nettype none
// onehot_dec: binary register select to one-hot enable vector.
// Revision 1.0
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] hot
);

  always_comb begin
    hot      = '0;
    hot[sel] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/param_control_unit.sv
`default_nettype none
// param_control_unit: multi-cycle bus sequencer with Run/Done/Busy handshake.
// Optional feature macro ILLEGAL_TRAP_EN adds the Illegal output. Revision 1.0
module param_control_unit
  import cu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int OPC_W    = 3,
  parameter int IR_W     = OPC_W + 2*SEL_W
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                Run,
  input  logic [IR_W-1:0]     IR,
  input  logic                GZero,
  output logic                IRin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                Ain,
  output logic                Gin,
  output logic                Gout,
  output logic                DINout,
  output logic [1:0]          AluOp,
  output logic                Busy,
`ifdef ILLEGAL_TRAP_EN
  output logic                Illegal,
`endif
  output logic                Done
);

  state_t               state, next_state;
  logic [OPC_W-1:0]     opc;
  logic [SEL_W-1:0]     rx, ry;
  logic [NUM_REGS-1:0]  rx_hot, ry_hot;
  logic [OPC_W-1:0]     ir_opc;
  logic                 illegal_int;

  assign ir_opc = IR[IR_W-1 -: OPC_W];

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      opc   <= '0;
      rx    <= '0;
      ry    <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH) {opc, rx, ry} <= IR;
    end
  end

  onehot_dec #(.SEL_W(SEL_W)) u_rx_dec (.sel(rx), .hot(rx_hot));
  onehot_dec #(.SEL_W(SEL_W)) u_ry_dec (.sel(ry), .hot(ry_hot));

  assign Busy = (state != IDLE);

  always_comb begin
    next_state  = state;
    IRin        = 1'b0;
    Rin         = '0;
    Rout        = '0;
    Ain         = 1'b0;
    Gin         = 1'b0;
    Gout        = 1'b0;
    DINout      = 1'b0;
    AluOp       = ALU_ADD;
    Done        = 1'b0;
    illegal_int = 1'b0;
    case (state)
      IDLE: if (Run) next_state = FETCH;
      FETCH: begin
        IRin = 1'b1;
        case (ir_opc)
          OPC_MV, OPC_MVNZ:          next_state = MV;
          OPC_MVI:                   next_state = MVI;
          OPC_ADD, OPC_SUB, OPC_AND: next_state = OP1;
          default:                   next_state = ILL;
        endcase
      end
      MV: begin
        Rout = ry_hot;
        // mvnz suppresses the write when G is zero
        if (!(opc == OPC_MVNZ && GZero)) Rin = rx_hot;
        Done       = 1'b1;
        next_state = IDLE;
      end
      MVI: begin
        DINout     = 1'b1;
        Rin        = rx_hot;
        Done       = 1'b1;
        next_state = IDLE;
      end
      OP1: begin
        Rout       = rx_hot;
        Ain        = 1'b1;
        next_state = OP2;
      end
      OP2: begin
        Rout = ry_hot;
        Gin  = 1'b1;
        case (opc)
          OPC_SUB: AluOp = ALU_SUB;
          OPC_AND: AluOp = ALU_AND;
          default: AluOp = ALU_ADD;
        endcase
        next_state = WB;
      end
      WB: begin
        Gout       = 1'b1;
        Rin        = rx_hot;
        Done       = 1'b1;
        next_state = IDLE;
      end
      ILL: begin
        Done        = 1'b1;
        illegal_int = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign Illegal = illegal_int;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_int;
`endif

endmodule
`default_nettype wire
